// File: rtl/button_press_classifier.sv
// Three-button front end: synchronise, debounce, classify inc presses as short/long, arbitrate pulses.
// Optional macro LONG_REPEAT_EN: while inc is held past the long threshold, emit inc_short every REPEAT_CYCLES.
module button_press_classifier #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned LONG_CYCLES     = 50000000,
   parameter int unsigned REPEAT_CYCLES   = 10000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_inc,
   input  logic btn_set,
   input  logic btn_sw,
   output logic inc_short,
   output logic inc_long,
   output logic set,
   output logic sw
);

   localparam int unsigned MAX_DL = (DEBOUNCE_CYCLES > LONG_CYCLES) ? DEBOUNCE_CYCLES : LONG_CYCLES;
   localparam int unsigned MAXP   = (MAX_DL > REPEAT_CYCLES) ? MAX_DL : REPEAT_CYCLES;
   localparam int unsigned CW     = ($clog2(MAXP + 1) < 1) ? 1 : $clog2(MAXP + 1);
   localparam int unsigned NB     = 3;
   localparam int unsigned NE     = 4;

   localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
   localparam logic [CW-1:0] CNT_MAX   = '1;
`ifdef LONG_REPEAT_EN
   localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);
`endif

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      HELD      = 2'd1,
      LONG_HELD = 2'd2
   } state_e;

   // Button index: 0 = inc, 1 = set, 2 = sw
   logic [NB-1:0] raw_c;
   logic [NB-1:0] sync1_q, sync2_q;
   logic [NB-1:0] lvl_q, lvl_d;
   logic [CW-1:0] db_cnt_q [NB];
   logic [CW-1:0] db_cnt_d [NB];
   logic [NB-1:0] rise_c;
   logic          inc_fall_c;

   state_e        state_q;
   logic [CW-1:0] hold_cnt_q;
`ifdef LONG_REPEAT_EN
   logic [CW-1:0] rep_cnt_q;
`endif
   logic          short_evt_c, long_evt_c;

   // Event index: 0 = inc_short, 1 = set, 2 = inc_long, 3 = sw (also the priority order)
   logic [NE-1:0] pend_q, pend_d;
   logic [NE-1:0] new_evt_c, grant_c;
   logic [NE-1:0] out_q;

   assign raw_c = {btn_sw, btn_set, btn_inc};

   // Two-flop synchronisers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= raw_c;
         sync2_q <= sync1_q;
      end
   end

   // Debounce: level flips after DEBOUNCE_CYCLES consecutive mismatching samples
   always_comb begin
      lvl_d = lvl_q;
      for (int i = 0; i < int'(NB); i++) begin
         db_cnt_d[i] = '0;
         if (sync2_q[i] != lvl_q[i]) begin
            if (db_cnt_q[i] == DB_LAST) begin
               lvl_d[i] = sync2_q[i];
            end else if (db_cnt_q[i] != CNT_MAX) begin
               db_cnt_d[i] = db_cnt_q[i] + CW'(1);
            end else begin
               db_cnt_d[i] = db_cnt_q[i];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lvl_q <= '0;
         for (int i = 0; i < int'(NB); i++) begin
            db_cnt_q[i] <= '0;
         end
      end else begin
         lvl_q <= lvl_d;
         for (int i = 0; i < int'(NB); i++) begin
            db_cnt_q[i] <= db_cnt_d[i];
         end
      end
   end

   assign rise_c     = lvl_d & ~lvl_q;
   assign inc_fall_c = lvl_q[0] & ~lvl_d[0];

   // Inc classification events; the long threshold wins over a simultaneous release
   always_comb begin
      short_evt_c = 1'b0;
      long_evt_c  = 1'b0;
      case (state_q)
         HELD: begin
            if (hold_cnt_q == LONG_LAST) begin
               long_evt_c = 1'b1;
            end else if (inc_fall_c) begin
               short_evt_c = 1'b1;
            end
         end
         LONG_HELD: begin
`ifdef LONG_REPEAT_EN
            if (!inc_fall_c && rep_cnt_q == REP_LAST) begin
               short_evt_c = 1'b1;
            end
`endif
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         hold_cnt_q <= '0;
`ifdef LONG_REPEAT_EN
         rep_cnt_q  <= '0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (rise_c[0]) begin
                  state_q    <= HELD;
                  hold_cnt_q <= '0;
               end
            end
            HELD: begin
               if (long_evt_c) begin
                  state_q <= inc_fall_c ? IDLE : LONG_HELD;
`ifdef LONG_REPEAT_EN
                  rep_cnt_q <= '0;
`endif
               end else if (inc_fall_c) begin
                  state_q <= IDLE;
               end else if (hold_cnt_q != CNT_MAX) begin
                  hold_cnt_q <= hold_cnt_q + CW'(1);
               end
            end
            LONG_HELD: begin
               if (inc_fall_c) begin
                  state_q <= IDLE;
               end
`ifdef LONG_REPEAT_EN
               else if (rep_cnt_q == REP_LAST) begin
                  rep_cnt_q <= '0;
               end else if (rep_cnt_q != CNT_MAX) begin
                  rep_cnt_q <= rep_cnt_q + CW'(1);
               end
`endif
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign new_evt_c = {rise_c[2], long_evt_c, rise_c[1], short_evt_c};

   // Fixed-priority grant over pending flags; losers stay pending
   always_comb begin
      grant_c = '0;
      if (pend_q[0]) begin
         grant_c[0] = 1'b1;
      end else if (pend_q[1]) begin
         grant_c[1] = 1'b1;
      end else if (pend_q[2]) begin
         grant_c[2] = 1'b1;
      end else if (pend_q[3]) begin
         grant_c[3] = 1'b1;
      end
      pend_d = (pend_q & ~grant_c) | new_evt_c;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q <= '0;
         out_q  <= '0;
      end else begin
         pend_q <= pend_d;
         out_q  <= grant_c;
      end
   end

   assign inc_short = out_q[0];
   assign set       = out_q[1];
   assign inc_long  = out_q[2];
   assign sw        = out_q[3];

endmodule

// File: tb/tb_button_press_classifier.sv
// Bench for button_press_classifier: directed scenarios plus random buttons against a timestamp-based model.
module tb_button_press_classifier;

   localparam int D  = 4;
   localparam int L  = 20;
   localparam int RP = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic btn_inc = 1'b0, btn_set = 1'b0, btn_sw = 1'b0;
   logic inc_short, inc_long, set, sw;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always #5 clk = ~clk;

   button_press_classifier #(
      .DEBOUNCE_CYCLES(D),
      .LONG_CYCLES    (L),
      .REPEAT_CYCLES  (RP)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .btn_inc  (btn_inc),
      .btn_set  (btn_set),
      .btn_sw   (btn_sw),
      .inc_short(inc_short),
      .inc_long (inc_long),
      .set      (set),
      .sw       (sw)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Reference model: sync delay, debounce run length, press age from timestamps, pending-set arbitration
   bit [2:0] m_s1, m_s2, m_lvl;
   int       m_run [3];
   bit       m_pressed;
   int       m_trise, m_t;
   bit [3:0] m_pend, m_out;

   always @(posedge clk or negedge rst_n) begin : model
      bit [2:0] rise, fall;
      bit [3:0] evt, grant;
      int       age;
      if (!rst_n) begin
         m_s1 = '0; m_s2 = '0; m_lvl = '0;
         for (int b = 0; b < 3; b++) m_run[b] = 0;
         m_pressed = 1'b0; m_trise = 0; m_t = 0;
         m_pend = '0; m_out = '0;
      end else begin
         rise = '0; fall = '0;
         for (int b = 0; b < 3; b++) begin
            if (m_s2[b] != m_lvl[b]) m_run[b]++;
            else m_run[b] = 0;
            if (m_run[b] == D) begin
               m_lvl[b] = ~m_lvl[b];
               m_run[b] = 0;
               if (m_lvl[b]) rise[b] = 1'b1;
               else fall[b] = 1'b1;
            end
         end
         m_s2 = m_s1;
         m_s1 = {btn_sw, btn_set, btn_inc};
         evt = {rise[2], 1'b0, rise[1], 1'b0};
         if (m_pressed) begin
            age = m_t - m_trise;
            if (age == L) evt[2] = 1'b1;
            else if (fall[0] && age < L) evt[0] = 1'b1;
`ifdef LONG_REPEAT_EN
            else if (!fall[0] && age > L && ((age - L) % RP) == 0) evt[0] = 1'b1;
`endif
            if (fall[0]) m_pressed = 1'b0;
         end
         if (rise[0]) begin
            m_pressed = 1'b1;
            m_trise   = m_t;
         end
         grant = '0;
         for (int e = 0; e < 4; e++) begin
            if (m_pend[e] && grant == 4'b0) grant[e] = 1'b1;
         end
         m_out  = grant;
         m_pend = (m_pend & ~grant) | evt;
         m_t++;
      end
   end

   // Per-cycle comparison and pulse bookkeeping
   int n_short = 0, n_long = 0, n_set = 0, n_sw = 0;
   int t_set = 0, t_sw = 0, t_long = 0;

   always @(negedge clk) begin
      if (rst_n) begin
         check("outputs_vs_model", 32'({sw, inc_long, set, inc_short}), 32'(m_out));
         check("onehot", 32'($countones({sw, inc_long, set, inc_short}) <= 1), 32'd1);
      end
      if (inc_short) n_short++;
      if (inc_long) begin n_long++; t_long = cyc; end
      if (set) begin n_set++; t_set = cyc; end
      if (sw) begin n_sw++; t_sw = cyc; end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   localparam int REP_EXP =
`ifdef LONG_REPEAT_EN
      2;
`else
      0;
`endif

   initial begin : stim
      int c0, s0, l0, e0, w0;
      int rem [3];
      bit [2:0] lv;
      int rst_hold;

      tick(3);
      #1 check("reset_outputs", 32'({sw, inc_long, set, inc_short}), 32'd0);
      @(negedge clk) rst_n = 1'b1;
      tick(5);

      // Single set press: one pulse DEBOUNCE+3 after the raw edge, nothing on release
      s0 = n_set; c0 = cyc;
      btn_set = 1'b1; tick(10);
      btn_set = 1'b0; tick(20);
      check("set_count", 32'(n_set - s0), 32'd1);
      check("set_latency", 32'(t_set - c0), 32'd7);

      // Bouncy short inc press
      s0 = n_short; l0 = n_long;
      btn_inc = 1'b1; tick(1);
      btn_inc = 1'b0; tick(1);
      btn_inc = 1'b1; tick(10);
      btn_inc = 1'b0; tick(40);
      check("bounce_short_count", 32'(n_short - s0), 32'd1);
      check("bounce_long_count", 32'(n_long - l0), 32'd0);

      // 40-cycle hold: one long pulse at threshold
      s0 = n_short; l0 = n_long; c0 = cyc;
      btn_inc = 1'b1; tick(40);
      btn_inc = 1'b0; tick(40);
      check("hold_long_count", 32'(n_long - l0), 32'd1);
      check("hold_long_latency", 32'(t_long - c0), 32'd27);
      check("hold_short_count", 32'(n_short - s0), 32'(REP_EXP));

      // Simultaneous set and sw: set first, sw the next cycle
      e0 = n_set; w0 = n_sw; c0 = cyc;
      btn_set = 1'b1; btn_sw = 1'b1; tick(10);
      btn_set = 1'b0; btn_sw = 1'b0; tick(20);
      check("dual_set_count", 32'(n_set - e0), 32'd1);
      check("dual_sw_count", 32'(n_sw - w0), 32'd1);
      check("dual_set_latency", 32'(t_set - c0), 32'd7);
      check("dual_sw_latency", 32'(t_sw - c0), 32'd8);

      // Reset mid-hold at count 10, then the still-held button is a fresh press
      s0 = n_short; l0 = n_long;
      btn_inc = 1'b1; tick(16);
      rst_n = 1'b0;
      #1 check("midhold_reset_outputs", 32'({sw, inc_long, set, inc_short}), 32'd0);
      tick(3);
      check("midhold_no_pulse", 32'((n_short - s0) + (n_long - l0)), 32'd0);
      rst_n = 1'b1;
      tick(40);
      check("fresh_long_count", 32'(n_long - l0), 32'd1);
      btn_inc = 1'b0; tick(30);
      check("fresh_short_count", 32'(n_short - s0), 32'(REP_EXP));

      // Random buttons with bounces, long holds and occasional resets
      lv = '0;
      for (int b = 0; b < 3; b++) rem[b] = int'($urandom_range(5, 30));
      rst_hold = 0;
      for (int c = 0; c < 5000; c++) begin
         for (int b = 0; b < 3; b++) begin
            if (rem[b] == 0) begin
               lv[b] = ~lv[b];
               rem[b] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                    : int'($urandom_range(4, 45));
            end else begin
               rem[b]--;
            end
         end
         btn_inc = lv[0]; btn_set = lv[1]; btn_sw = lv[2];
         if (rst_hold > 0) begin
            rst_hold--;
            if (rst_hold == 0) rst_n = 1'b1;
         end else if ($urandom_range(0, 1499) == 0) begin
            rst_n = 1'b0;
            rst_hold = 2;
         end
         tick(1);
      end
      rst_n = 1'b1;
      btn_inc = 1'b0; btn_set = 1'b0; btn_sw = 1'b0;
      tick(60);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
